// File: rtl/seq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM states and
// instruction field positions.
package seq_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_MOV = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  localparam int unsigned OP_HI  = 7;
  localparam int unsigned OP_LO  = 5;
  localparam int unsigned RD_POS = 4;
  localparam int unsigned RS_POS = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StExec  = 2'd2,
    StWrite = 2'd3
  } seqState_e;

  // Opcodes that produce a register-file write; NOP and reserved do not.
  function automatic logic opWrites(input logic [2:0] op);
    logic w;
    unique case (op)
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI: w = 1'b1;
      default:                                       w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/alu8.sv
// Combinational ALU for the sequencer: a is the rd operand, b the rs operand.
// LDI is not handled here; the top substitutes the immediate.
module alu8
  import seq_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c,
  output logic              flagUpdate
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide       = '0;
    result     = '0;
    c          = 1'b0;
    flagUpdate = 1'b0;
    unique case (op)
      OP_MOV: result = b;
      OP_ADD: begin
        wide       = {1'b0, a} + {1'b0, b};
        result     = wide[DATA_W-1:0];
        c          = wide[DATA_W];
        flagUpdate = 1'b1;
      end
      // The extra top bit of the widened difference is the unsigned borrow.
      OP_SUB: begin
        wide       = {1'b0, a} - {1'b0, b};
        result     = wide[DATA_W-1:0];
        c          = wide[DATA_W];
        flagUpdate = 1'b1;
      end
      OP_AND: begin
        result     = a & b;
        flagUpdate = 1'b1;
      end
      OP_OR: begin
        result     = a | b;
        flagUpdate = 1'b1;
      end
      default: ;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle sequencer driving a two-entry register file: IDLE -> READ -> EXEC -> WRITE,
// one instruction per four cycles.
module regfile_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMM_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr,
  output logic              rf_read_a,
  output logic              rf_read_b,
  input  logic [DATA_W-1:0] rf_out_a,
  input  logic [DATA_W-1:0] rf_out_b,
  output logic              rf_we,
  output logic              rf_wr_reg,
  output logic [DATA_W-1:0] rf_in_data,
  output logic              done,
  output logic              flag_z,
  output logic              flag_c
);

  seqState_e         stateQ, stateD;
  logic [7:0]        instrQ;
  logic              readAQ, readBQ;
  logic              weQ, wrRegQ, doneQ, flagZQ, flagCQ;
  logic [DATA_W-1:0] inDataQ;

  logic [2:0]        opQ;
  logic [DATA_W-1:0] aluResult, wrData;
  logic              aluZ, aluC, aluFlagUpdate;

  assign opQ = instrQ[OP_HI:OP_LO];

  alu8 #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a         (rf_out_a),
    .b         (rf_out_b),
    .op        (opQ),
    .result    (aluResult),
    .z         (aluZ),
    .c         (aluC),
    .flagUpdate(aluFlagUpdate)
  );

  assign wrData = (opQ == OP_LDI) ? {{(DATA_W-IMM_W){1'b0}}, instrQ[IMM_W-1:0]} : aluResult;

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (instr_valid) stateD = StRead;
      StRead:  stateD = StExec;
      StExec:  stateD = StWrite;
      StWrite: stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ  <= StIdle;
      instrQ  <= '0;
      readAQ  <= 1'b0;
      readBQ  <= 1'b0;
      weQ     <= 1'b0;
      wrRegQ  <= 1'b0;
      inDataQ <= '0;
      doneQ   <= 1'b0;
      flagZQ  <= 1'b0;
      flagCQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      weQ    <= 1'b0;
      doneQ  <= 1'b0;
      // Selects are set on the accept edge so they are stable for all of READ.
      if (stateQ == StIdle && instr_valid) begin
        instrQ <= instr;
        readAQ <= instr[RD_POS];
        readBQ <= instr[RS_POS];
      end
      // Operands are sampled at the end of EXEC; write fields then hold through WRITE.
      if (stateQ == StExec) begin
        weQ     <= opWrites(opQ);
        wrRegQ  <= instrQ[RD_POS];
        inDataQ <= wrData;
        doneQ   <= 1'b1;
        if (aluFlagUpdate) begin
          flagZQ <= aluZ;
          flagCQ <= aluC;
        end
      end
    end
  end

  assign instr_ready = (stateQ == StIdle) && !reset;
  assign rf_read_a   = readAQ;
  assign rf_read_b   = readBQ;
  assign rf_we       = weQ;
  assign rf_wr_reg   = wrRegQ;
  assign rf_in_data  = inDataQ;
  assign done        = doneQ;
  assign flag_z      = flagZQ;
  assign flag_c      = flagCQ;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a behavioural two-entry register file plus an
// instruction-level reference model of registers and flags.
module tb_regfile_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       instr_ready, rf_read_a, rf_read_b, rf_we, rf_wr_reg, done, flag_z, flag_c;
  logic [7:0] rf_out_a, rf_out_b, rf_in_data;

  int total = 0;
  int bad = 0;

  regfile_sequencer #(
    .DATA_W(8),
    .IMM_W (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .rf_read_a  (rf_read_a),
    .rf_read_b  (rf_read_b),
    .rf_out_a   (rf_out_a),
    .rf_out_b   (rf_out_b),
    .rf_we      (rf_we),
    .rf_wr_reg  (rf_wr_reg),
    .rf_in_data (rf_in_data),
    .done       (done),
    .flag_z     (flag_z),
    .flag_c     (flag_c)
  );

  always #5 clock = ~clock;

  logic [7:0] rf [2] = '{8'h00, 8'h00};
  assign rf_out_a = rf[rf_read_a];
  assign rf_out_b = rf[rf_read_b];
  always @(posedge clock) if (rf_we) rf[rf_wr_reg] <= rf_in_data;

  // Reference model: architectural effect of one instruction.
  logic [7:0] mRf [2] = '{8'h00, 8'h00};
  logic       mZ = 1'b0;
  logic       mC = 1'b0;

  function automatic void model_exec(input logic [7:0] ins);
    int op, d, s, a, b, r;
    op = int'(ins[7:5]);
    d  = int'(ins[4]);
    s  = int'(ins[3]);
    a  = int'(mRf[d]);
    b  = int'(mRf[s]);
    case (op)
      1: mRf[d] = mRf[s];
      2: begin r = a + b; mC = (r > 255); r = r % 256; mZ = (r == 0); mRf[d] = 8'(r); end
      3: begin mC = (a < b); r = (a - b + 256) % 256; mZ = (r == 0); mRf[d] = 8'(r); end
      4: begin r = a & b; mC = 1'b0; mZ = (r == 0); mRf[d] = 8'(r); end
      5: begin r = a | b; mC = 1'b0; mZ = (r == 0); mRf[d] = 8'(r); end
      6: mRf[d] = {4'h0, ins[3:0]};
      default: ;
    endcase
  endfunction

  // Observations from the most recent issue(); index n is the nth negedge after acceptance.
  logic [3:0] obsDone, obsWe;
  logic       obsWrReg, obsRdA, obsRdB, obsReady;
  logic [7:0] obsWrData;

  task automatic issue(input logic [7:0] ins);
    int guard = 0;
    while (!instr_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (!instr_ready) begin
      total++; bad++;
      $display("FAIL issue_ready_timeout got=0 want=1");
    end
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    instr = 8'($urandom);
    obsDone = '0;
    obsWe = '0;
    for (int n = 0; n < 4; n++) begin
      if (n > 0) @(negedge clock);
      obsDone[n] = done;
      obsWe[n] = rf_we;
      if (rf_we) begin obsWrReg = rf_wr_reg; obsWrData = rf_in_data; end
      if (n == 0) begin obsRdA = rf_read_a; obsRdB = rf_read_b; end
    end
    obsReady = instr_ready;
    model_exec(ins);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if (instr_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%b want=0", instr_ready);
    end
    total++;
    if ({rf_we, rf_wr_reg, rf_read_a, rf_read_b, done, flag_z, flag_c} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0000000",
               {rf_we, rf_wr_reg, rf_read_a, rf_read_b, done, flag_z, flag_c});
    end
    total++;
    if (rf_in_data !== 8'h00) begin
      bad++; $display("FAIL reset_data got=%h want=00", rf_in_data);
    end
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (instr_ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL reset_release ready/done got=%b%b want=10", instr_ready, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] doneSeen, weSeen, d2, d6;
    logic       r2, r6;
    instr = 8'hC5;
    instr_valid = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      doneSeen[n] = done;
      weSeen[n] = rf_we;
      if (n == 2) begin d2 = rf_in_data; r2 = rf_wr_reg; end
      if (n == 6) begin d6 = rf_in_data; r6 = rf_wr_reg; end
      if (n == 3) instr = 8'hD3;
      if (n == 4) begin instr_valid = 1'b0; instr = 8'h00; end
    end
    model_exec(8'hC5);
    model_exec(8'hD3);
    total++;
    if (doneSeen !== 8'b0100_0100) begin
      bad++; $display("FAIL b2b_done got=%b want=01000100", doneSeen);
    end
    total++;
    if (weSeen !== 8'b0100_0100) begin
      bad++; $display("FAIL b2b_we got=%b want=01000100", weSeen);
    end
    total++;
    if (d2 !== 8'h05 || r2 !== 1'b0 || d6 !== 8'h03 || r6 !== 1'b1) begin
      bad++; $display("FAIL b2b_writes got=%b:%h %b:%h want=0:05 1:03", r2, d2, r6, d6);
    end
    total++;
    if (rf[0] !== 8'h05 || rf[1] !== 8'h03) begin
      bad++; $display("FAIL b2b_regs got=%h,%h want=05,03", rf[0], rf[1]);
    end
  endtask

  task automatic test_arith();
    issue(8'h48);
    total++;
    if (rf[0] !== 8'h08 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
      bad++; $display("FAIL add_5_3 got=r0 %h z%b c%b want=r0 08 z0 c0", rf[0], flag_z, flag_c);
    end
    total++;
    if (obsDone !== 4'b0100 || obsWe !== 4'b0100 || obsWrData !== 8'h08) begin
      bad++; $display("FAIL add_timing got=done %b we %b data %h want=0100 0100 08",
                      obsDone, obsWe, obsWrData);
    end
    issue(8'h70);
    total++;
    if (rf[1] !== 8'hFB || flag_z !== 1'b0 || flag_c !== 1'b1) begin
      bad++; $display("FAIL sub_borrow got=r1 %h z%b c%b want=r1 fb z0 c1", rf[1], flag_z, flag_c);
    end
  endtask

  task automatic test_wrap_and_mov();
    issue(8'hC0);
    issue(8'hD1);
    issue(8'h68);
    total++;
    if (rf[0] !== 8'hFF || flag_c !== 1'b1) begin
      bad++; $display("FAIL sub_to_ff got=r0 %h c%b want=r0 ff c1", rf[0], flag_c);
    end
    issue(8'h48);
    total++;
    if (rf[0] !== 8'h00 || flag_z !== 1'b1 || flag_c !== 1'b1) begin
      bad++; $display("FAIL add_wrap got=r0 %h z%b c%b want=r0 00 z1 c1", rf[0], flag_z, flag_c);
    end
    issue(8'h30);
    total++;
    if (rf[1] !== 8'h00 || flag_z !== 1'b1 || flag_c !== 1'b1) begin
      bad++; $display("FAIL mov_keeps_flags got=r1 %h z%b c%b want=r1 00 z1 c1",
                      rf[1], flag_z, flag_c);
    end
  endtask

  task automatic test_nop_reserved();
    logic [7:0] opList [2];
    opList[0] = 8'h00;
    opList[1] = 8'hE7;
    for (int i = 0; i < 2; i++) begin
      issue(opList[i]);
      total++;
      if (obsDone !== 4'b0100 || obsWe !== 4'b0000) begin
        bad++; $display("FAIL nop_%0d got=done %b we %b want=0100 0000", i, obsDone, obsWe);
      end
      total++;
      if (rf[0] !== mRf[0] || rf[1] !== mRf[1] || flag_z !== mZ || flag_c !== mC) begin
        bad++; $display("FAIL nop_state_%0d got=%h %h z%b c%b want=%h %h z%b c%b", i,
                        rf[0], rf[1], flag_z, flag_c, mRf[0], mRf[1], mZ, mC);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic weAny = 1'b0;
    issue(8'hC6);
    issue(8'hD2);
    instr = 8'h48;
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    weAny |= rf_we;
    mZ = 1'b0;
    mC = 1'b0;
    total++;
    if ({rf_we, done, flag_z, flag_c, rf_read_a, rf_read_b, instr_ready} !== 7'b0
        || rf_in_data !== 8'h00) begin
      bad++; $display("FAIL midop_reset_outputs got=%b %h want=0000000 00",
                      {rf_we, done, flag_z, flag_c, rf_read_a, rf_read_b, instr_ready},
                      rf_in_data);
    end
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (instr_ready !== 1'b1) begin
      bad++; $display("FAIL midop_ready_after got=%b want=1", instr_ready);
    end
    repeat (3) begin
      @(negedge clock);
      weAny |= rf_we | done;
    end
    total++;
    if (weAny !== 1'b0 || rf[0] !== 8'h06 || rf[1] !== 8'h02) begin
      bad++; $display("FAIL midop_no_write got=we %b regs %h,%h want=we 0 regs 06,02",
                      weAny, rf[0], rf[1]);
    end
  endtask

  task automatic test_idle_pulse();
    logic act = 1'b0;
    logic rdy = 1'b1;
    instr_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      instr = 8'($urandom);
      @(negedge clock);
      act |= rf_we | done;
      rdy &= instr_ready;
    end
    total++;
    if (act !== 1'b0 || rdy !== 1'b1) begin
      bad++; $display("FAIL idle_quiet got=activity %b ready %b want=0 1", act, rdy);
    end
    issue(8'h50);
    total++;
    if (rf[0] !== mRf[0] || rf[1] !== mRf[1] || obsDone !== 4'b0100) begin
      bad++; $display("FAIL idle_pulse_exec got=%h %h done %b want=%h %h done 0100",
                      rf[0], rf[1], obsDone, mRf[0], mRf[1]);
    end
  endtask

  task automatic test_random();
    logic [7:0] ins;
    logic       writes;
    for (int i = 0; i < 40; i++) begin
      ins = 8'($urandom);
      writes = (ins[7:5] != 3'd0) && (ins[7:5] != 3'd7);
      issue(ins);
      total++;
      if (rf[0] !== mRf[0] || rf[1] !== mRf[1]) begin
        bad++; $display("FAIL rand_regs i=%0d ins=%h got=%h %h want=%h %h",
                        i, ins, rf[0], rf[1], mRf[0], mRf[1]);
      end
      total++;
      if (flag_z !== mZ || flag_c !== mC) begin
        bad++; $display("FAIL rand_flags i=%0d ins=%h got=z%b c%b want=z%b c%b",
                        i, ins, flag_z, flag_c, mZ, mC);
      end
      total++;
      if (obsDone !== 4'b0100 || obsWe !== (writes ? 4'b0100 : 4'b0000) || obsReady !== 1'b1) begin
        bad++; $display("FAIL rand_timing i=%0d ins=%h got=done %b we %b rdy %b want=0100 %b 1",
                        i, ins, obsDone, obsWe, obsReady, writes ? 4'b0100 : 4'b0000);
      end
      total++;
      if (obsRdA !== ins[4] || obsRdB !== ins[3] || (writes && obsWrReg !== ins[4])) begin
        bad++; $display("FAIL rand_selects i=%0d ins=%h got=a%b b%b w%b want=a%b b%b w%b",
                        i, ins, obsRdA, obsRdB, obsWrReg, ins[4], ins[3], ins[4]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_arith();
    test_wrap_and_mov();
    test_nop_reserved();
    test_reset_midop();
    test_idle_pulse();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
